frame_ram_arbiter: RTL and testbench



---
 rtl/frame_ram_arbiter.sv | 90 +++++++++
 tb/tb_frame_ram_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: single-port frame RAM controller, ring of committed frames, write-first arbitration with reader starvation bound
module frame_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int MAX_WR_STREAK = 4,
  parameter int FRAME_Q = 8
) (
  input  logic                      mainclk,
  input  logic                      rst,
  input  logic                      wr_valid,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_last,
  output logic                      wr_ready,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_wr_ena,
  output logic [DATA_W-1:0]         ram_wr_data,
  input  logic [DATA_W-1:0]         ram_rd_data,
  output logic [$clog2(FRAME_Q):0]  frames_avail,
  output logic                      overflow
);
  localparam int QW = $clog2(FRAME_Q);
  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic W_ACCEPT = 1'b0;
  localparam logic W_DROP = 1'b1;
  logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr, used;
  logic [ADDR_W:0] fq [FRAME_Q];
  logic [QW-1:0] q_head, q_tail;
  logic [SW-1:0] streak;
  logic state, full, readable, q_full, rd_pend, grant_wr, grant_rd, accept, drop, push, pop;
  assign used = wr_ptr - rd_ptr;
  assign full = used == {1'b1, {ADDR_W{1'b0}}};
  assign readable = rd_ptr != commit_ptr;
  assign q_full = frames_avail == (QW+1)'(FRAME_Q);
  assign rd_pend = ~rst & rd_req_valid & readable;
  assign grant_wr = ~rst & wr_valid & (~rd_pend | streak < SW'(MAX_WR_STREAK));
  assign grant_rd = rd_pend & ~grant_wr;
  assign accept = grant_wr & state == W_ACCEPT;
  assign drop = accept & (full | wr_last & q_full);
  assign push = accept & ~full & wr_last & ~q_full;
  // the queue is never empty while readable, so the head is always a real frame end
  assign pop = grant_rd & rd_ptr == fq[q_head];
  assign wr_ready = grant_wr;
  assign rd_req_ready = grant_rd;
  assign ram_addr = grant_wr ? wr_ptr[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];
  assign ram_wr_ena = accept & ~full;
  assign ram_wr_data = wr_data;
  assign rd_data = rd_valid ? ram_rd_data : '0;
  always_ff @(posedge mainclk)
    if (push) fq[q_tail] <= wr_ptr;
  always_ff @(posedge mainclk) begin
    if (rst) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      q_head <= '0;
      q_tail <= '0;
      frames_avail <= '0;
      streak <= '0;
      state <= W_ACCEPT;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_valid <= grant_rd;
      rd_last <= pop;
      if (grant_rd) rd_ptr <= rd_ptr + 1'b1;
      streak <= (grant_rd | ~rd_pend) ? '0 : (grant_wr && streak < SW'(MAX_WR_STREAK)) ? streak + 1'b1 : streak;
      if (push) begin
        q_tail <= q_tail + 1'b1;
        commit_ptr <= wr_ptr + 1'b1;
      end
      if (pop) q_head <= q_head + 1'b1;
      frames_avail <= frames_avail + (QW+1)'(push) - (QW+1)'(pop);
      if (drop) begin
        wr_ptr <= commit_ptr;
        overflow <= 1'b1;
        state <= wr_last ? W_ACCEPT : W_DROP;
      end else if (accept & ~full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else if (grant_wr & wr_last) begin
        state <= W_ACCEPT;
      end
    end
  end
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb_frame_ram_arbiter: randomized traffic against a frame-level reference model
module tb_frame_ram_arbiter;
  logic mainclk = 1'b0, rst = 1'b1;
  logic wr_valid = 1'b0, wr_last = 1'b0, rd_req_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic wr_ready, rd_req_ready, rd_valid, rd_last, ram_wr_ena, overflow;
  logic [31:0] rd_data, ram_wr_data, ram_rd_data;
  logic [8:0] ram_addr;
  logic [3:0] frames_avail;
  logic [31:0] mem [512];
  int total = 0, bad = 0;

  frame_ram_arbiter dut (
    .mainclk(mainclk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .ram_addr(ram_addr),
    .ram_wr_ena(ram_wr_ena), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
    .frames_avail(frames_avail), .overflow(overflow)
  );

  always #5 mainclk = ~mainclk;

  always @(posedge mainclk) begin
    if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end

  typedef struct {logic [31:0] d; logic l;} ent_t;
  ent_t cq[$];
  logic [31:0] pq[$];
  int flens[$];
  int m_frames = 0, streak = 0, waddr = 0, raddr = 0;
  bit m_ovf = 0, dropping = 0, exp_rv = 0, exp_rl = 0, after_rst = 0, wauto = 0;
  logic [31:0] exp_rd = '0;
  int cur_len = 0, widx = 0, pw = 100, pr = 0, maxlen = 8;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r);
    bit rd_pend, gw, gr, full, qfull;
    ent_t e;
    if (after_rst) check("rst_rd_data", rd_data, 0);
    check("rd_valid", rd_valid, exp_rv);
    if (exp_rv) begin
      check("rd_data", rd_data, exp_rd);
      check("rd_last", rd_last, exp_rl);
    end
    check("frames_avail", frames_avail, m_frames);
    check("overflow", overflow, m_ovf);
    rst = r;
    if (!r && cur_len == 0 && (flens.size() > 0 || wauto)) begin
      if (flens.size() > 0) cur_len = flens.pop_front();
      else cur_len = $urandom_range(1, maxlen);
      widx = 0;
    end
    wr_valid = cur_len > 0 && $urandom_range(99) < pw;
    wr_last = cur_len > 0 && widx == cur_len - 1;
    wr_data = $urandom;
    rd_req_valid = $urandom_range(99) < pr;
    #1;
    if (r) begin
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_req_ready", rd_req_ready, 0);
      check("rst_ram_wr_ena", ram_wr_ena, 0);
      cq.delete(); pq.delete(); flens.delete();
      m_frames = 0; streak = 0; waddr = 0; raddr = 0;
      m_ovf = 0; dropping = 0; exp_rv = 0; cur_len = 0; widx = 0;
    end else begin
      rd_pend = rd_req_valid && cq.size() > 0;
      gw = wr_valid && (!rd_pend || streak < 4);
      gr = rd_pend && !gw;
      full = cq.size() + pq.size() == 512;
      qfull = m_frames == 8;
      check("wr_ready", wr_ready, gw);
      check("rd_req_ready", rd_req_ready, gr);
      check("ram_wr_ena", ram_wr_ena, gw && !dropping && !full);
      if (gw) check("wr_addr", ram_addr, waddr & 511);
      if (gr) check("rd_addr", ram_addr, raddr & 511);
      if (gw && !dropping && !full) check("ram_wr_data", ram_wr_data, wr_data);
      if (gr || !rd_pend) streak = 0;
      else if (gw && streak < 4) streak++;
      exp_rv = gr;
      if (gr) begin
        e = cq.pop_front();
        exp_rd = e.d; exp_rl = e.l;
        if (e.l) m_frames--;
        raddr++;
      end
      if (gw) begin
        if (dropping) begin
          if (wr_last) dropping = 0;
        end else if (full || (wr_last && qfull)) begin
          waddr -= pq.size();
          pq.delete();
          m_ovf = 1;
          dropping = !wr_last;
        end else begin
          pq.push_back(wr_data);
          waddr++;
          if (wr_last) begin
            foreach (pq[i]) cq.push_back('{pq[i], i == pq.size() - 1});
            pq.delete();
            m_frames++;
          end
        end
        widx++;
        if (wr_last) begin cur_len = 0; widx = 0; end
      end
    end
    after_rst = r;
    @(negedge mainclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic do_reset();
    step(1);
    step(1);
  endtask

  initial begin
    @(negedge mainclk);
    do_reset();
    // one 3-word frame, then read it back
    wauto = 0; pw = 100; pr = 0; flens = '{3};
    run(5);
    check("frameA_avail", frames_avail, 1);
    pr = 100;
    run(6);
    check("frameA_drained", frames_avail, 0);
    // continuous writer and reader exercise the streak bound
    wauto = 1; maxlen = 8; pw = 100; pr = 100;
    run(200);
    do_reset();
    // fill to full: 511-word frame then a 2-word frame that overflows
    wauto = 0; pw = 100; pr = 0; flens = '{511, 2};
    run(520);
    check("full_overflow", overflow, 1);
    check("full_frames", frames_avail, 1);
    pr = 100; run(4);
    pr = 0; flens = '{1}; run(4);
    pr = 100; run(530);
    do_reset();
    // frame queue limit
    pr = 0; flens = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run(12);
    check("qfull_frames", frames_avail, 8);
    check("qfull_overflow", overflow, 1);
    pr = 100; run(12);
    do_reset();
    // long mixed traffic wrapping the ring several times
    wauto = 1; maxlen = 40; pw = 70; pr = 60;
    run(4000);
    pw = 0; pr = 100; wauto = 0; run(600);
    // reset in the middle of a frame
    do_reset();
    pw = 100; pr = 0; flens = '{5};
    run(1);
    step(1);
    flens = '{2}; run(4);
    pr = 100; run(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
